fab_mdu: RTL

FAB_MDU -- requirements
Module: fab_mdu

---
 rtl/fab_mdu.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/fab_mdu.sv
// RISC-V M-extension multiply/divide unit: iterative shift-add multiply and
// restoring divide, one bit per cycle, with stall, flush and fast-path early outs.
module fab_mdu #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned TAG_W = 1
) (
    input  logic             clk,
    input  logic             rst_s1,
    input  logic             stop,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [XLEN-1:0]  rfrdata1,
    input  logic [XLEN-1:0]  rfrdata2,
    input  logic [4:0]       rd,
    input  logic [TAG_W-1:0] num_in,
    output logic             busy,
    output logic [4:0]       busy_rd,
    output logic             out_valid,
    output logic [TAG_W-1:0] num_out,
    output logic             rfwe,
    output logic [4:0]       rfwaddr,
    output logic [XLEN-1:0]  rfwdata
);

    localparam int unsigned CNT_W = $clog2(XLEN) + 1;
    localparam int unsigned PW    = 2 * XLEN;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       op_q, op_d;
    logic [4:0]       rd_q, rd_d;
    logic [TAG_W-1:0] tag_q, tag_d;
    logic             neg_q, neg_d;
    logic [XLEN-1:0]  mg_q, mg_d;
    logic [XLEN:0]    hi_q, hi_d;
    logic [XLEN-1:0]  lo_q, lo_d;
    logic             out_valid_q, out_valid_d;
    logic             rfwe_q, rfwe_d;
    logic [4:0]       rfwaddr_q, rfwaddr_d;
    logic [XLEN-1:0]  rfwdata_q, rfwdata_d;
    logic [TAG_W-1:0] num_out_q, num_out_d;

    // Operand decode at accept time: signedness, magnitudes, result sign, early outs
    logic            signed_a, signed_b, na, nb, neg_in, fast_in;
    logic [XLEN-1:0] mag_a, mag_b;
    assign signed_a = op[2] ? !op[0] : (op[1:0] != 2'b11);
    assign signed_b = op[2] ? !op[0] : !op[1];
    assign na       = signed_a & rfrdata1[XLEN-1];
    assign nb       = signed_b & rfrdata2[XLEN-1];
    assign mag_a    = na ? -rfrdata1 : rfrdata1;
    assign mag_b    = nb ? -rfrdata2 : rfrdata2;
    // Remainder sign follows A only; quotient and products take sign(A) xor sign(B)
    assign neg_in   = na ^ (nb & !(op[2] & op[1]));
    assign fast_in  = op[2] & ((rfrdata2 == '0) |
                      (!op[0] & (rfrdata1 == {1'b1, {(XLEN-1){1'b0}}}) & (&rfrdata2)));

    // One iteration step of each algorithm
    logic [XLEN:0] mul_sum, div_trial, div_diff;
    logic          div_ge;
    assign mul_sum   = hi_q + {1'b0, (lo_q[0] ? mg_q : {XLEN{1'b0}})};
    assign div_trial = {hi_q[XLEN-1:0], lo_q[XLEN-1]};
    assign div_ge    = div_trial >= {1'b0, mg_q};
    assign div_diff  = div_trial - {1'b0, mg_q};

    // Final result selection with sign correction
    logic [PW-1:0]   prod, prod_s;
    logic [XLEN-1:0] div_raw, div_res, result;
    assign prod    = {hi_q[XLEN-1:0], lo_q};
    assign prod_s  = neg_q ? -prod : prod;
    assign div_raw = op_q[1] ? hi_q[XLEN-1:0] : lo_q;
    assign div_res = neg_q ? -div_raw : div_raw;
    assign result  = op_q[2] ? div_res :
                     (op_q[1:0] == 2'b00) ? prod_s[XLEN-1:0] : prod_s[PW-1:XLEN];

    assign in_ready  = (state_q == IDLE) && !stop && !flush;
    assign busy      = (state_q == CALC) || (state_q == DONE);
    assign busy_rd   = busy ? rd_q : 5'd0;
    assign out_valid = out_valid_q;
    assign rfwe      = rfwe_q;
    assign rfwaddr   = rfwaddr_q;
    assign rfwdata   = rfwdata_q;
    assign num_out   = num_out_q;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        op_d        = op_q;
        rd_d        = rd_q;
        tag_d       = tag_q;
        neg_d       = neg_q;
        mg_d        = mg_q;
        hi_d        = hi_q;
        lo_d        = lo_q;
        out_valid_d = out_valid_q;
        rfwe_d      = rfwe_q;
        rfwaddr_d   = rfwaddr_q;
        rfwdata_d   = rfwdata_q;
        num_out_d   = num_out_q;
        if (flush) begin
            state_d     = IDLE;
            cnt_d       = '0;
            out_valid_d = 1'b0;
            rfwe_d      = 1'b0;
        end else if (!stop) begin
            out_valid_d = 1'b0;
            rfwe_d      = 1'b0;
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        op_d  = op;
                        rd_d  = rd;
                        tag_d = num_in;
                        cnt_d = '0;
                        if (fast_in) begin
                            state_d = DONE;
                            neg_d   = 1'b0;
                            if (rfrdata2 == '0) begin
                                lo_d = '1;
                                hi_d = {1'b0, rfrdata1};
                            end else begin
                                lo_d = rfrdata1;
                                hi_d = '0;
                            end
                        end else begin
                            state_d = CALC;
                            neg_d   = neg_in;
                            hi_d    = '0;
                            mg_d    = op[2] ? mag_b : mag_a;
                            lo_d    = op[2] ? mag_a : mag_b;
                        end
                    end
                end
                CALC: begin
                    if (op_q[2]) begin
                        hi_d = div_ge ? div_diff : div_trial;
                        lo_d = {lo_q[XLEN-2:0], div_ge};
                    end else begin
                        hi_d = {1'b0, mul_sum[XLEN:1]};
                        lo_d = {mul_sum[0], lo_q[XLEN-1:1]};
                    end
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(XLEN - 1)) begin
                        state_d = DONE;
                    end
                end
                DONE: begin
                    state_d     = IDLE;
                    out_valid_d = 1'b1;
                    rfwe_d      = (rd_q != 5'd0);
                    rfwaddr_d   = rd_q;
                    rfwdata_d   = result;
                    num_out_d   = tag_q;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst_s1) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            op_q        <= '0;
            rd_q        <= '0;
            tag_q       <= '0;
            neg_q       <= 1'b0;
            mg_q        <= '0;
            hi_q        <= '0;
            lo_q        <= '0;
            out_valid_q <= 1'b0;
            rfwe_q      <= 1'b0;
            rfwaddr_q   <= '0;
            rfwdata_q   <= '0;
            num_out_q   <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            op_q        <= op_d;
            rd_q        <= rd_d;
            tag_q       <= tag_d;
            neg_q       <= neg_d;
            mg_q        <= mg_d;
            hi_q        <= hi_d;
            lo_q        <= lo_d;
            out_valid_q <= out_valid_d;
            rfwe_q      <= rfwe_d;
            rfwaddr_q   <= rfwaddr_d;
            rfwdata_q   <= rfwdata_d;
            num_out_q   <= num_out_d;
        end
    end

endmodule
